stack_controller: RTL and testbench

Multi-cycle control FSM for the 8-bit stack-machine datapath. It sits directly upstream of the datapath and drives every datapath control strobe. It consumes the 3-bit opcode (IR[7:5]) and the accumulator zero flag from the datapath. One instruction runs as a fixed sequence of states starting from FETCH.

---
 rtl/stack_controller_pkg.sv | 44 ++++
 rtl/stack_controller_if.sv | 40 ++++
 rtl/stack_controller.sv | 124 ++++++++++++
 tb/tb_stack_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stack_controller_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
//   Shared definitions for the stack-machine control FSM: field widths,
//   opcode encodings (IR[7:5]), ALU operation selects and the controller
//   state enumeration.
//   Ports: none (package only).
// ---------------------------------------------------------------------------
package stack_pkg;

  localparam int INST_W  = 3;
  localparam int ALUOP_W = 2;

  // Opcode encodings as they appear in IR[7:5]
  localparam logic [INST_W-1:0] OP_ADD  = 3'b000;
  localparam logic [INST_W-1:0] OP_SUB  = 3'b001;
  localparam logic [INST_W-1:0] OP_AND  = 3'b010;
  localparam logic [INST_W-1:0] OP_NOT  = 3'b011;
  localparam logic [INST_W-1:0] OP_PUSH = 3'b100;
  localparam logic [INST_W-1:0] OP_POP  = 3'b101;
  localparam logic [INST_W-1:0] OP_JMP  = 3'b110;
  localparam logic [INST_W-1:0] OP_JZ   = 3'b111;

  // ALU operation selects; ALU opcodes carry these in their low two bits
  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_NOT = 2'b11;

  // Controller states; encodings 11..15 are illegal and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POPA   = 4'd2,
    S_POPB   = 4'd3,
    S_EXEC   = 4'd4,
    S_PUSHR  = 4'd5,
    S_MEMRD  = 4'd6,
    S_PUSHM  = 4'd7,
    S_MEMWR  = 4'd8,
    S_JUMP   = 4'd9,
    S_JZCHK  = 4'd10
  } ctrl_state_t;

endpackage

// File: rtl/stack_controller_if.sv
// ---------------------------------------------------------------------------
// stack_controller_if
//   Bundle between the control FSM and the 8-bit stack-machine datapath.
//   Datapath -> controller: inst (IR[7:5]), zero (A == 0).
//   Controller -> datapath: ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB,
//   PCup, PCwrite, J, JZ, write_enable, ALUop.
//   Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface stack_controller_if;
  import stack_pkg::*;

  logic [INST_W-1:0]  inst;
  logic               zero;
  logic               ld_IR;
  logic               PCorIR;
  logic               push;
  logic               pop;
  logic               MEMorALU;
  logic               ldA;
  logic               ldB;
  logic               PCup;
  logic               PCwrite;
  logic               J;
  logic               JZ;
  logic               write_enable;
  logic [ALUOP_W-1:0] ALUop;

  modport master (
    input  inst, zero,
    output ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB,
           PCup, PCwrite, J, JZ, write_enable, ALUop
  );

  modport slave (
    output inst, zero,
    input  ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB,
           PCup, PCwrite, J, JZ, write_enable, ALUop
  );

endinterface

// File: rtl/stack_controller.sv
// ---------------------------------------------------------------------------
// stack_controller
//   Multi-cycle control FSM for the 8-bit stack-machine datapath. Each
//   instruction walks a fixed state sequence starting at FETCH; strobes are
//   Moore-decoded from the state (PCwrite in JZCHK follows zero).
//   Ports:
//     clk  - state register clock (posedge); datapath captures on negedge
//     rst  - synchronous active-high reset; forces all strobes low, state FETCH
//     bus  - stack_controller_if.master: inst/zero in, control strobes out
// ---------------------------------------------------------------------------
module stack_controller (
  input  logic                      clk,
  input  logic                      rst,
  stack_controller_if.master        bus
);
  import stack_pkg::*;

  ctrl_state_t         state_q, state_d;
  logic [INST_W-1:0]   opcode_q, opcode_d;

  // State and opcode registers. The opcode is captured while IR is known to
  // be stable (DECODE) so EXEC can pick its ALU operation without relying on
  // the inst port later in the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state logic. inst only steers the sequence in DECODE and POPA.
  always_comb begin
    state_d  = S_FETCH;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.inst;
        case (bus.inst)
          OP_PUSH: state_d = S_MEMRD;
          OP_JMP:  state_d = S_JUMP;
          default: state_d = S_POPA;
        endcase
      end
      S_POPA: begin
        case (bus.inst)
          OP_ADD, OP_SUB, OP_AND: state_d = S_POPB;
          OP_NOT:                 state_d = S_EXEC;
          OP_POP:                 state_d = S_MEMWR;
          OP_JZ:                  state_d = S_JZCHK;
          default:                state_d = S_FETCH;
        endcase
      end
      S_POPB:  state_d = S_EXEC;
      S_EXEC:  state_d = S_PUSHR;
      S_PUSHR: state_d = S_FETCH;
      S_MEMRD: state_d = S_PUSHM;
      S_PUSHM: state_d = S_FETCH;
      S_MEMWR: state_d = S_FETCH;
      S_JUMP:  state_d = S_FETCH;
      S_JZCHK: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode. Everything defaults low; reset masks all strobes so the
  // datapath sees no activity in a cycle where the sequence is abandoned.
  always_comb begin
    bus.ld_IR        = 1'b0;
    bus.PCorIR       = 1'b0;
    bus.push         = 1'b0;
    bus.pop          = 1'b0;
    bus.MEMorALU     = 1'b0;
    bus.ldA          = 1'b0;
    bus.ldB          = 1'b0;
    bus.PCup         = 1'b0;
    bus.PCwrite      = 1'b0;
    bus.J            = 1'b0;
    bus.JZ           = 1'b0;
    bus.write_enable = 1'b0;
    bus.ALUop        = ALU_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.ld_IR = 1'b1;
          bus.PCup  = 1'b1;
        end
        S_DECODE: bus.PCwrite = 1'b1;
        S_POPA: begin
          bus.ldA = 1'b1;
          bus.pop = 1'b1;
        end
        S_POPB: begin
          bus.ldB = 1'b1;
          bus.pop = 1'b1;
        end
        S_EXEC:  bus.ALUop = opcode_q[ALUOP_W-1:0];
        S_PUSHR: begin
          bus.MEMorALU = 1'b1;
          bus.push     = 1'b1;
        end
        S_MEMRD: bus.PCorIR = 1'b1;
        S_PUSHM: bus.push   = 1'b1;
        S_MEMWR: begin
          bus.PCorIR       = 1'b1;
          bus.write_enable = 1'b1;
        end
        S_JUMP: begin
          bus.J       = 1'b1;
          bus.PCwrite = 1'b1;
        end
        S_JZCHK: begin
          bus.JZ      = 1'b1;
          bus.PCwrite = bus.zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// ---------------------------------------------------------------------------
// tb_stack_controller
//   Self-checking bench for stack_controller. Each instruction's expected
//   strobe pattern is derived from a per-opcode list of phase names and a
//   phase-to-strobe table; inst is scrambled in phases where it is ignored.
// ---------------------------------------------------------------------------
module tb_stack_controller;
  import stack_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  string phaseQ[$];

  stack_controller_if busIf ();

  stack_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf.master)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed strobes packed as
  // {ld_IR,PCorIR,push,pop,MEMorALU,ldA,ldB,PCup,PCwrite,J,JZ,we,ALUop}
  function automatic logic [13:0] observed();
    return {busIf.ld_IR, busIf.PCorIR, busIf.push, busIf.pop, busIf.MEMorALU,
            busIf.ldA, busIf.ldB, busIf.PCup, busIf.PCwrite, busIf.J,
            busIf.JZ, busIf.write_enable, busIf.ALUop};
  endfunction

  // Strobes required in a named phase of an instruction
  function automatic logic [13:0] expectFor(string ph, logic [2:0] op, logic z);
    logic [13:0] e;
    e = '0;
    case (ph)
      "FETCH":  begin e[13] = 1'b1; e[6] = 1'b1; end
      "DECODE": e[5] = 1'b1;
      "POPA":   begin e[8] = 1'b1; e[10] = 1'b1; end
      "POPB":   begin e[7] = 1'b1; e[10] = 1'b1; end
      "EXEC":   e[1:0] = op[1:0];
      "PUSHR":  begin e[9] = 1'b1; e[11] = 1'b1; end
      "MEMRD":  e[12] = 1'b1;
      "PUSHM":  e[11] = 1'b1;
      "MEMWR":  begin e[12] = 1'b1; e[2] = 1'b1; end
      "JUMP":   begin e[4] = 1'b1; e[5] = 1'b1; end
      "JZCHK":  begin e[3] = 1'b1; e[5] = z; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  // Phase list of one instruction, FETCH up to (not including) next FETCH
  task automatic buildSeq(input logic [2:0] op);
    phaseQ.delete();
    phaseQ.push_back("FETCH");
    phaseQ.push_back("DECODE");
    case (op)
      3'b000, 3'b001, 3'b010: begin
        phaseQ.push_back("POPA"); phaseQ.push_back("POPB");
        phaseQ.push_back("EXEC"); phaseQ.push_back("PUSHR");
      end
      3'b011: begin
        phaseQ.push_back("POPA"); phaseQ.push_back("EXEC");
        phaseQ.push_back("PUSHR");
      end
      3'b100: begin phaseQ.push_back("MEMRD"); phaseQ.push_back("PUSHM"); end
      3'b101: begin phaseQ.push_back("POPA"); phaseQ.push_back("MEMWR"); end
      3'b110: phaseQ.push_back("JUMP");
      default: begin phaseQ.push_back("POPA"); phaseQ.push_back("JZCHK"); end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Runs one instruction starting in a FETCH cycle (just after posedge).
  // zMode: 0/1 forces zero, 2 randomizes it each cycle. abortAt >= 0 pulses
  // reset in that phase instead of completing the instruction.
  task automatic applyStimulus(input logic [2:0] op, input int zMode,
                               input int abortAt);
    logic z;
    buildSeq(op);
    for (int k = 0; k < phaseQ.size(); k++) begin
      busIf.inst = (k <= 2) ? op : 3'($urandom_range(0, 7));
      z = (zMode == 2) ? 1'($urandom_range(0, 1)) : 1'(zMode);
      busIf.zero = z;
      if (k == abortAt) begin
        rst = 1'b1;
        #1;
        checkOutput($sformatf("rst_mid_%s", phaseQ[k]), 14'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      #1;
      checkOutput($sformatf("op%0d_%s_k%0d", op, phaseQ[k], k),
                  expectFor(phaseQ[k], op, z));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    busIf.inst = 3'b000;
    busIf.zero = 1'b0;

    // Two reset cycles with noisy inputs: every strobe must stay low
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      busIf.inst = 3'($urandom_range(0, 7));
      busIf.zero = 1'($urandom_range(0, 1));
      #1;
      checkOutput($sformatf("reset_%0d", i), 14'b0);
    end
    rst = 1'b0;

    // Directed: every opcode once, JZ with both zero values
    applyStimulus(OP_ADD,  2, -1);
    applyStimulus(OP_SUB,  2, -1);
    applyStimulus(OP_AND,  2, -1);
    applyStimulus(OP_NOT,  2, -1);
    applyStimulus(OP_PUSH, 2, -1);
    applyStimulus(OP_POP,  2, -1);
    applyStimulus(OP_JZ,   1, -1);
    applyStimulus(OP_JZ,   0, -1);
    applyStimulus(OP_JMP,  2, -1);

    // Reset pulse during EXEC of an ADD, then a clean instruction
    applyStimulus(OP_ADD, 2, 4);
    applyStimulus(OP_SUB, 2, -1);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), 2, -1);
    end

    // Random mid-instruction resets
    for (int n = 0; n < 10; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), 2, $urandom_range(0, 2));
      applyStimulus(3'($urandom_range(0, 7)), 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
